// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter.
//   MEM_IDLE / MEM_READ / MEM_WRITE : downstream {write,read} flag encodings
//   arb_state_e                     : arbiter FSM states (IDLE -> ISSUE -> RESP)
//   normalize_flag()                : maps the illegal 2'b11 request onto a write
package mem_arbiter_pkg;

  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

  // A requester that raises both bits is served as a write so the downstream
  // port never sees an undefined command.
  function automatic logic [1:0] normalize_flag(input logic [1:0] flag);
    return (flag == 2'b11) ? MEM_WRITE : flag;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of every handshake/bus signal around the memory-port arbiter.
//   req_*  : packed two-channel requester side (ch0 = DCACHE in the low slice,
//            ch1 = ICACHE in the high slice)
//   mem_*  : single downstream memory-controller port
//   grant_o: one-hot current owner
// Modports:
//   slave  : the arbiter itself (serves the requesters, drives the memory port)
//   master : the surrounding environment (caches + memory controller)
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
);

  logic [3:0]          req_rw_flag_i;
  logic [2*ADDR_W-1:0] req_addr_i;
  logic [2*DATA_W-1:0] req_w_data_i;
  logic [2*MASK_W-1:0] req_w_mask_i;
  logic [2*DATA_W-1:0] req_r_data_o;
  logic [1:0]          req_busy_o;
  logic [1:0]          req_done_o;
  logic [1:0]          mem_rw_flag_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   mem_w_data_o;
  logic [MASK_W-1:0]   mem_w_mask_o;
  logic [DATA_W-1:0]   mem_r_data_i;
  logic                mem_busy_i;
  logic                mem_done_i;
  logic [1:0]          grant_o;

  modport slave (
    input  req_rw_flag_i, req_addr_i, req_w_data_i, req_w_mask_i,
    input  mem_r_data_i, mem_busy_i, mem_done_i,
    output req_r_data_o, req_busy_o, req_done_o,
    output mem_rw_flag_o, mem_addr_o, mem_w_data_o, mem_w_mask_o,
    output grant_o
  );

  modport master (
    output req_rw_flag_i, req_addr_i, req_w_data_i, req_w_mask_i,
    output mem_r_data_i, mem_busy_i, mem_done_i,
    input  req_r_data_o, req_busy_o, req_done_o,
    input  mem_rw_flag_o, mem_addr_o, mem_w_data_o, mem_w_mask_o,
    input  grant_o
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way picker.
//   pending    : channels with a nonzero request flag
//   mask       : channels in cooldown, not allowed to win this cycle
//   last_grant : channel served most recently (0 = ch0, 1 = ch1)
//   winner     : one-hot winning channel, 0 when nobody is eligible
// ROUND_ROBIN = 1 gives a tie to the channel not served last;
// ROUND_ROBIN = 0 always gives a tie to ch0.
module rr_arb2 #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic [1:0] pending,
  input  logic [1:0] mask,
  input  logic       last_grant,
  output logic [1:0] winner
);

  logic [1:0] eligible;

  // Only a tie needs a decision; a single eligible channel simply wins.
  always_comb begin
    eligible = pending & ~mask;
    winner   = eligible;
    if (eligible == 2'b11) begin
      if ((ROUND_ROBIN != 0) && (last_grant == 1'b0)) begin
        winner = 2'b10;
      end else begin
        winner = 2'b01;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory-controller port between the DCACHE (ch0) and ICACHE (ch1).
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : mem_arbiter_if.slave carrying the packed requester channels,
//              the downstream memory port and the one-hot grant
// Flow: IDLE picks a winner and latches its request, ISSUE drives it downstream
// until the controller completes, RESP pulses done for one cycle and masks the
// winner for the following IDLE cycle so it can drop its flag.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MASK_W      = 4,
  parameter int ROUND_ROBIN = 1
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  arb_state_e          state_q, state_d;
  logic                owner_q, owner_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          cool_q, cool_d;
  logic                last_grant_q, last_grant_d;
  logic [1:0]          issue_flag_q, issue_flag_d;
  logic [ADDR_W-1:0]   issue_addr_q, issue_addr_d;
  logic [DATA_W-1:0]   issue_data_q, issue_data_d;
  logic [MASK_W-1:0]   issue_mask_q, issue_mask_d;
  logic [2*DATA_W-1:0] r_data_q, r_data_d;
  logic [1:0]          done_q, done_d;
  logic [1:0]          pending;
  logic [1:0]          winner;

  assign pending = {|bus.req_rw_flag_i[3:2], |bus.req_rw_flag_i[1:0]};

  rr_arb2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
    .pending    (pending),
    .mask       (cool_q),
    .last_grant (last_grant_q),
    .winner     (winner)
  );

  // Next-state logic. The cooldown mask and the done pulse default to zero so
  // each lives for exactly one cycle after being set.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    issue_flag_d = issue_flag_q;
    issue_addr_d = issue_addr_q;
    issue_data_d = issue_data_q;
    issue_mask_d = issue_mask_q;
    r_data_d     = r_data_q;
    done_d       = 2'b00;
    cool_d       = 2'b00;
    case (state_q)
      ARB_IDLE: begin
        if (winner != 2'b00) begin
          owner_d      = winner[1];
          grant_d      = winner;
          last_grant_d = winner[1];
          state_d      = ARB_ISSUE;
          if (winner[1]) begin
            issue_flag_d = normalize_flag(bus.req_rw_flag_i[3:2]);
            issue_addr_d = bus.req_addr_i[2*ADDR_W-1:ADDR_W];
            issue_data_d = bus.req_w_data_i[2*DATA_W-1:DATA_W];
            issue_mask_d = bus.req_w_mask_i[2*MASK_W-1:MASK_W];
          end else begin
            issue_flag_d = normalize_flag(bus.req_rw_flag_i[1:0]);
            issue_addr_d = bus.req_addr_i[ADDR_W-1:0];
            issue_data_d = bus.req_w_data_i[DATA_W-1:0];
            issue_mask_d = bus.req_w_mask_i[MASK_W-1:0];
          end
        end
      end
      ARB_ISSUE: begin
        if (bus.mem_done_i && !bus.mem_busy_i) begin
          if (issue_flag_q == MEM_READ) begin
            if (owner_q) begin
              r_data_d[2*DATA_W-1:DATA_W] = bus.mem_r_data_i;
            end else begin
              r_data_d[DATA_W-1:0] = bus.mem_r_data_i;
            end
          end
          done_d  = owner_q ? 2'b10 : 2'b01;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        grant_d = 2'b00;
        cool_d  = grant_q;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // All arbiter state, including the registered response outputs. Reset also
  // abandons any in-flight downstream access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= 1'b0;
      grant_q      <= 2'b00;
      cool_q       <= 2'b00;
      last_grant_q <= 1'b1;
      issue_flag_q <= MEM_IDLE;
      issue_addr_q <= '0;
      issue_data_q <= '0;
      issue_mask_q <= '0;
      r_data_q     <= '0;
      done_q       <= 2'b00;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      cool_q       <= cool_d;
      last_grant_q <= last_grant_d;
      issue_flag_q <= issue_flag_d;
      issue_addr_q <= issue_addr_d;
      issue_data_q <= issue_data_d;
      issue_mask_q <= issue_mask_d;
      r_data_q     <= r_data_d;
      done_q       <= done_d;
    end
  end

  // Catch requesters that raise both read and write at once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (bus.req_rw_flag_i[1:0] != 2'b11);
      assert (bus.req_rw_flag_i[3:2] != 2'b11);
    end
  end

  // The downstream port is only driven while a request is in flight.
  assign bus.mem_rw_flag_o = (state_q == ARB_ISSUE) ? issue_flag_q : MEM_IDLE;
  assign bus.mem_addr_o    = (state_q == ARB_ISSUE) ? issue_addr_q : '0;
  assign bus.mem_w_data_o  = (state_q == ARB_ISSUE) ? issue_data_q : '0;
  assign bus.mem_w_mask_o  = (state_q == ARB_ISSUE) ? issue_mask_q : '0;

  // grant_q is still set during RESP, so it selects the channel whose busy
  // drops in its completion cycle.
  assign bus.req_busy_o   = pending & ~((state_q == ARB_RESP) ? grant_q : 2'b00);
  assign bus.req_done_o   = done_q;
  assign bus.req_r_data_o = r_data_q;
  assign bus.grant_o      = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized two-channel phase, checked against a transaction-level model
// (reference memory, access log, per-channel expected read data).
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef struct {
    logic [1:0]  flag;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [1:0]  grant;
    logic [31:0] rdata;
  } access_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .ROUND_ROBIN(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  logic [31:0] ref_mem [logic [31:0]];
  access_t     acc_log [$];
  access_t     resp_entry;
  int          mem_busy_cycles = 0;
  int          resp_cnt;
  int          resp_target;
  bit          resp_active;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] cur;
    cur = mem_read(a);
    for (int b = 0; b < 4; b++) if (m[b]) cur[8*b +: 8] = d[8*b +: 8];
    ref_mem[a] = cur;
  endtask

  // Memory controller model: busy for a chosen number of cycles, then one done
  // pulse; every completed access is logged and applied to the reference memory.
  always @(negedge clk) begin
    if (rst || bus.mem_rw_flag_o == MEM_IDLE) begin
      bus.mem_busy_i   = 1'b0;
      bus.mem_done_i   = 1'b0;
      bus.mem_r_data_i = '0;
      resp_active      = 1'b0;
      resp_cnt         = 0;
    end else begin
      if (!resp_active) begin
        resp_active = 1'b1;
        resp_target = mem_busy_cycles;
        resp_cnt    = 0;
      end
      if (resp_cnt < resp_target) begin
        bus.mem_busy_i = 1'b1;
        bus.mem_done_i = 1'b0;
        resp_cnt++;
      end else begin
        resp_entry.flag  = bus.mem_rw_flag_o;
        resp_entry.addr  = bus.mem_addr_o;
        resp_entry.wdata = bus.mem_w_data_o;
        resp_entry.mask  = bus.mem_w_mask_o;
        resp_entry.grant = bus.grant_o;
        resp_entry.rdata = mem_read(bus.mem_addr_o);
        if (bus.mem_rw_flag_o == MEM_WRITE)
          mem_write(bus.mem_addr_o, bus.mem_w_data_o, bus.mem_w_mask_o);
        acc_log.push_back(resp_entry);
        bus.mem_busy_i   = 1'b0;
        bus.mem_done_i   = 1'b1;
        bus.mem_r_data_i = resp_entry.rdata;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic [1:0] flag, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] mask);
    bus.req_rw_flag_i[2*ch +: 2]  = flag;
    bus.req_addr_i[32*ch +: 32]   = addr;
    bus.req_w_data_i[32*ch +: 32] = data;
    bus.req_w_mask_i[4*ch +: 4]   = mask;
  endtask

  // Waits (bounded) for any done pulse; a timeout returns done_bits = 0.
  task automatic waitAnyDone(input int max_cycles, output logic [1:0] done_bits, output int flag_cycles);
    done_bits   = 2'b00;
    flag_cycles = 0;
    for (int i = 0; i < max_cycles && done_bits == 2'b00; i++) begin
      @(negedge clk);
      if (bus.mem_rw_flag_o != MEM_IDLE) flag_cycles++;
      done_bits = bus.req_done_o;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  done_bits;
    int          flag_cycles;
    int          last_served;
    int          exp_ch;
    int          log_len;
    logic [31:0] exp_val;
    logic [31:0] exp_rdata [2];
    int          req_left [2];
    bit          active [2];
    logic [1:0]  cur_flag [2];
    logic [31:0] cur_addr [2];
    logic [31:0] cur_data [2];
    logic [3:0]  cur_mask [2];
    int          served;
    int          log_base;

    bus.req_rw_flag_i = '0;
    bus.req_addr_i    = '0;
    bus.req_w_data_i  = '0;
    bus.req_w_mask_i  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("reset grant", 64'(bus.grant_o), 64'h0);
    checkOutput("reset done", 64'(bus.req_done_o), 64'h0);
    checkOutput("reset busy", 64'(bus.req_busy_o), 64'h0);
    checkOutput("reset mem flag", 64'(bus.mem_rw_flag_o), 64'h0);
    checkOutput("reset mem addr", 64'(bus.mem_addr_o), 64'h0);
    checkOutput("reset r_data", 64'(bus.req_r_data_o), 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Simultaneous reads on both channels, two rounds; the model tracks which
    // channel was served last, starting from ch1 out of reset.
    $display("[TB] tie arbitration");
    mem_busy_cycles = 0;
    last_served = 1;
    for (int round = 0; round < 2; round++) begin
      applyStimulus(0, MEM_READ, 32'h40 + 32'(round * 8), 32'h0, 4'h0);
      applyStimulus(1, MEM_READ, 32'h80 + 32'(round * 8), 32'h0, 4'h0);
      for (int k = 0; k < 2; k++) begin
        exp_ch = (k == 0) ? 1 - last_served : 1 - exp_ch;
        waitAnyDone(20, done_bits, flag_cycles);
        checkOutput("tie done order", 64'(done_bits), 64'(2'b01 << exp_ch));
        checkOutput("tie grant", 64'(acc_log[acc_log.size()-1].grant), 64'(2'b01 << exp_ch));
        for (int c = 0; c < 2; c++) if (done_bits[c]) applyStimulus(c, MEM_IDLE, 32'h0, 32'h0, 4'h0);
        last_served = exp_ch;
      end
      applyStimulus(0, MEM_IDLE, 32'h0, 32'h0, 4'h0);
      applyStimulus(1, MEM_IDLE, 32'h0, 32'h0, 4'h0);
      repeat (2) @(negedge clk);
    end

    // ch0 read with three busy cycles from the controller.
    $display("[TB] single read");
    mem_busy_cycles = 3;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    applyStimulus(0, MEM_READ, 32'h100, 32'h0, 4'h0);
    #1;
    checkOutput("read busy at once", 64'(bus.req_busy_o), 64'h1);
    @(negedge clk);
    checkOutput("read latency flag", 64'(bus.mem_rw_flag_o), 64'(MEM_READ));
    checkOutput("read addr", 64'(bus.mem_addr_o), 64'h100);
    checkOutput("read grant", 64'(bus.grant_o), 64'h1);
    waitAnyDone(20, done_bits, flag_cycles);
    checkOutput("read flag cycles", 64'(flag_cycles + 1), 64'd4);
    checkOutput("read done", 64'(done_bits), 64'h1);
    checkOutput("read resp mem flag", 64'(bus.mem_rw_flag_o), 64'h0);
    checkOutput("read data", 64'(bus.req_r_data_o[31:0]), 64'hDEAD_BEEF);
    applyStimulus(0, MEM_IDLE, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("read done one cycle", 64'(bus.req_done_o), 64'h0);
    checkOutput("read grant cleared", 64'(bus.grant_o), 64'h0);
    @(negedge clk);

    // ch0 partial write: data path and mask reach the port, read data untouched.
    $display("[TB] single write");
    mem_busy_cycles = 1;
    log_len = acc_log.size();
    applyStimulus(0, MEM_WRITE, 32'h200, 32'h1234_5678, 4'b0011);
    @(negedge clk);
    checkOutput("write flag", 64'(bus.mem_rw_flag_o), 64'(MEM_WRITE));
    checkOutput("write addr", 64'(bus.mem_addr_o), 64'h200);
    checkOutput("write data", 64'(bus.mem_w_data_o), 64'h1234_5678);
    checkOutput("write mask", 64'(bus.mem_w_mask_o), 64'h3);
    waitAnyDone(20, done_bits, flag_cycles);
    checkOutput("write done", 64'(done_bits), 64'h1);
    checkOutput("write keeps r_data", 64'(bus.req_r_data_o[31:0]), 64'hDEAD_BEEF);
    applyStimulus(0, MEM_IDLE, 32'h0, 32'h0, 4'h0);
    checkOutput("write access count", 64'(acc_log.size()), 64'(log_len + 1));
    repeat (2) @(negedge clk);

    // ch1 owns the port; ch0 arrives mid-access and must wait for it.
    $display("[TB] no preemption");
    mem_busy_cycles = 4;
    applyStimulus(1, MEM_READ, 32'h300, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    applyStimulus(0, MEM_READ, 32'h304, 32'h0, 4'h0);
    #1;
    checkOutput("late busy", 64'(bus.req_busy_o), 64'h3);
    checkOutput("owner kept", 64'(bus.grant_o), 64'h2);
    waitAnyDone(20, done_bits, flag_cycles);
    checkOutput("owner done first", 64'(done_bits), 64'h2);
    checkOutput("owner r_data", 64'(bus.req_r_data_o[63:32]), 64'(mem_read(32'h300)));
    applyStimulus(1, MEM_IDLE, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("gap cycle grant", 64'(bus.grant_o), 64'h0);
    checkOutput("waiter still busy", 64'(bus.req_busy_o), 64'h1);
    @(negedge clk);
    checkOutput("waiter granted", 64'(bus.grant_o), 64'h1);
    waitAnyDone(20, done_bits, flag_cycles);
    checkOutput("waiter done", 64'(done_bits), 64'h1);
    checkOutput("waiter r_data", 64'(bus.req_r_data_o[31:0]), 64'(mem_read(32'h304)));
    applyStimulus(0, MEM_IDLE, 32'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);

    // Requester holds its flag one cycle past done; still one access only.
    $display("[TB] cooldown");
    mem_busy_cycles = 0;
    log_len = acc_log.size();
    applyStimulus(0, MEM_READ, 32'h400, 32'h0, 4'h0);
    waitAnyDone(20, done_bits, flag_cycles);
    checkOutput("cool done", 64'(done_bits), 64'h1);
    @(negedge clk);
    checkOutput("cool no regrant", 64'(bus.grant_o), 64'h0);
    checkOutput("cool mem idle", 64'(bus.mem_rw_flag_o), 64'h0);
    applyStimulus(0, MEM_IDLE, 32'h0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    checkOutput("cool single access", 64'(acc_log.size()), 64'(log_len + 1));

    // Reset while the controller stalls an access.
    $display("[TB] reset mid-issue");
    mem_busy_cycles = 1000;
    applyStimulus(0, MEM_READ, 32'h500, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    checkOutput("stall in issue", 64'(bus.mem_rw_flag_o), 64'(MEM_READ));
    rst = 1'b1;
    applyStimulus(0, MEM_IDLE, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("rst mem flag", 64'(bus.mem_rw_flag_o), 64'h0);
    checkOutput("rst mem addr", 64'(bus.mem_addr_o), 64'h0);
    checkOutput("rst grant", 64'(bus.grant_o), 64'h0);
    checkOutput("rst done", 64'(bus.req_done_o), 64'h0);
    checkOutput("rst r_data", 64'(bus.req_r_data_o), 64'h0);
    rst = 1'b0;
    mem_busy_cycles = 2;
    @(negedge clk);
    exp_val = mem_read(32'h504);
    applyStimulus(1, MEM_READ, 32'h504, 32'h0, 4'h0);
    waitAnyDone(20, done_bits, flag_cycles);
    checkOutput("post-rst done", 64'(done_bits), 64'h2);
    checkOutput("post-rst r_data", 64'(bus.req_r_data_o), {exp_val, 32'h0});
    applyStimulus(1, MEM_IDLE, 32'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);

    // Randomized traffic on both channels.
    $display("[TB] random traffic");
    exp_rdata[0] = 32'h0;
    exp_rdata[1] = exp_val;
    req_left[0] = 15;
    req_left[1] = 15;
    active[0] = 1'b0;
    active[1] = 1'b0;
    served = 0;
    log_base = acc_log.size();
    for (int cyc = 0; cyc < 3000 && served < 30; cyc++) begin
      @(negedge clk);
      mem_busy_cycles = $urandom_range(0, 3);
      for (int ch = 0; ch < 2; ch++) begin
        if (active[ch]) begin
          if (bus.req_done_o[ch]) begin
            checkOutput("rand busy at done", 64'(bus.req_busy_o[ch]), 64'h0);
            checkOutput("rand access count", 64'(acc_log.size()), 64'(log_base + served + 1));
            resp_entry = acc_log[acc_log.size()-1];
            checkOutput("rand flag", 64'(resp_entry.flag), 64'(cur_flag[ch]));
            checkOutput("rand addr", 64'(resp_entry.addr), 64'(cur_addr[ch]));
            checkOutput("rand wdata", 64'(resp_entry.wdata), 64'(cur_data[ch]));
            checkOutput("rand mask", 64'(resp_entry.mask), 64'(cur_mask[ch]));
            checkOutput("rand grant", 64'(resp_entry.grant), 64'(2'b01 << ch));
            if (cur_flag[ch] == MEM_READ) exp_rdata[ch] = resp_entry.rdata;
            checkOutput("rand r_data", 64'(bus.req_r_data_o[32*ch +: 32]), 64'(exp_rdata[ch]));
            applyStimulus(ch, MEM_IDLE, cur_addr[ch], cur_data[ch], cur_mask[ch]);
            active[ch] = 1'b0;
            served++;
          end else begin
            checkOutput("rand busy", 64'(bus.req_busy_o[ch]), 64'h1);
          end
        end else begin
          checkOutput("rand spurious done", 64'(bus.req_done_o[ch]), 64'h0);
          if (req_left[ch] > 0 && $urandom_range(0, 2) == 0) begin
            cur_flag[ch] = ($urandom_range(0, 1) == 0) ? MEM_READ : MEM_WRITE;
            cur_addr[ch] = 32'h1000 + 32'($urandom_range(0, 15) * 4);
            cur_data[ch] = $urandom;
            cur_mask[ch] = 4'($urandom_range(0, 15));
            applyStimulus(ch, cur_flag[ch], cur_addr[ch], cur_data[ch], cur_mask[ch]);
            active[ch] = 1'b1;
            req_left[ch]--;
          end
        end
      end
    end
    checkOutput("rand all served", 64'(served), 64'd30);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
